mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/gpu_pkg.sv | 13 +
 rtl/rr_picker.sv | 31 +++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared channel-state encoding and sizing helper for mem_arbiter
package gpu_pkg;
    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        READ_WAITING  = 2'd1,
        WRITE_WAITING = 2'd2,
        RELAYING      = 2'd3
    } ch_state_t;

    function automatic int ptr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - one-hot round-robin pick of the first unexcluded request at or after ptr
module rr_picker
    import gpu_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_bits(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  excl,
    output logic [N-1:0]  grant
);
    logic [N-1:0] avail;
    logic         found;

    assign avail = req & ~excl;

    // Walk distances from ptr outward; constant loop indices keep the selects static.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && avail[j] && (j == (int'(ptr) + i) % N)) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin LSU-to-memory channel arbiter; define MEM_ARB_WRITE_EN for the write path
module mem_arbiter
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);
    localparam int PW = ptr_bits(NUM_CONSUMERS);

    ch_state_t                state    [NUM_CHANNELS];
    logic [PW-1:0]            owner    [NUM_CHANNELS];
    logic [PW-1:0]            take_idx [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  take_any;
    logic [NUM_CONSUMERS-1:0] claimed;
    logic [NUM_CONSUMERS-1:0] req;
    logic [PW-1:0]            rr_ptr;

`ifdef MEM_ARB_WRITE_EN
    assign req = consumer_read_valid | consumer_write_valid;
`else
    logic unused_write;
    assign req                  = consumer_read_valid;
    assign mem_write_valid      = '0;
    assign mem_write_address    = '0;
    assign mem_write_data       = '0;
    assign consumer_write_ready = '0;
    assign unused_write = ^{consumer_write_valid, consumer_write_address,
                            consumer_write_data, mem_write_ready};
`endif

    // Lower channels pick first; each later channel excludes what earlier ones took.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [NUM_CONSUMERS-1:0] excl, grant, take, mask_out;
        logic [PW-1:0]            idx;

        if (c == 0) begin : g_first
            assign excl = claimed;
        end else begin : g_next
            assign excl = g_ch[c-1].mask_out;
        end

        rr_picker #(.N(NUM_CONSUMERS), .PW(PW)) u_pick (
            .req   (req),
            .ptr   (rr_ptr),
            .excl  (excl),
            .grant (grant)
        );

        assign take     = (state[c] == IDLE) ? grant : '0;
        assign mask_out = excl | take;

        always_comb begin
            idx = '0;
            for (int j = 0; j < NUM_CONSUMERS; j++)
                if (take[j]) idx = PW'(j);
        end

        assign take_any[c] = |take;
        assign take_idx[c] = idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state[c] <= IDLE;
                owner[c] <= '0;
            end
            claimed             <= '0;
            rr_ptr              <= '0;
            mem_read_valid      <= '0;
            mem_read_address    <= '0;
            consumer_read_ready <= '0;
            consumer_read_data  <= '0;
`ifdef MEM_ARB_WRITE_EN
            mem_write_valid      <= '0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            consumer_write_ready <= '0;
`endif
        end else begin
            // Ascending channel order: the highest granting channel sets rr_ptr last.
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (state[c])
                    IDLE: if (take_any[c]) begin
                        owner[c]              <= take_idx[c];
                        claimed[take_idx[c]]  <= 1'b1;
                        rr_ptr <= (int'(take_idx[c]) == NUM_CONSUMERS - 1) ? '0 : take_idx[c] + 1'b1;
                        if (consumer_read_valid[take_idx[c]]) begin
                            mem_read_valid[c]   <= 1'b1;
                            mem_read_address[c] <= consumer_read_address[take_idx[c]];
                            state[c]            <= READ_WAITING;
                        end
`ifdef MEM_ARB_WRITE_EN
                        else begin
                            mem_write_valid[c]   <= 1'b1;
                            mem_write_address[c] <= consumer_write_address[take_idx[c]];
                            mem_write_data[c]    <= consumer_write_data[take_idx[c]];
                            state[c]             <= WRITE_WAITING;
                        end
`endif
                    end
                    READ_WAITING: if (mem_read_ready[c]) begin
                        mem_read_valid[c]                <= 1'b0;
                        consumer_read_ready[owner[c]]    <= 1'b1;
                        consumer_read_data[owner[c]]     <= mem_read_data[c];
                        state[c]                         <= RELAYING;
                    end
`ifdef MEM_ARB_WRITE_EN
                    WRITE_WAITING: if (mem_write_ready[c]) begin
                        mem_write_valid[c]             <= 1'b0;
                        consumer_write_ready[owner[c]] <= 1'b1;
                        state[c]                       <= RELAYING;
                    end
`endif
                    // The raised ready strobe identifies which valid must drop to release.
                    RELAYING: if ((consumer_read_ready[owner[c]] && !consumer_read_valid[owner[c]])
`ifdef MEM_ARB_WRITE_EN
                                  || (consumer_write_ready[owner[c]] && !consumer_write_valid[owner[c]])
`endif
                                 ) begin
                        consumer_read_ready[owner[c]]  <= 1'b0;
`ifdef MEM_ARB_WRITE_EN
                        consumer_write_ready[owner[c]] <= 1'b0;
`endif
                        claimed[owner[c]] <= 1'b0;
                        state[c]          <= IDLE;
                    end
                    default: state[c] <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with one- and two-channel instances
`timescale 1ns/1ps
module tb_mem_arbiter;
    import gpu_pkg::*;

    localparam int AB = 8;
    localparam int DB = 8;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NC-1:0]          rd_valid, rd_ready, wr_valid, wr_ready;
    logic [NC-1:0][AB-1:0]  rd_addr, wr_addr;
    logic [NC-1:0][DB-1:0]  rd_data, wr_data;
    logic [0:0]             m_rd_valid, m_rd_ready, m_wr_valid, m_wr_ready;
    logic [0:0][AB-1:0]     m_rd_addr, m_wr_addr;
    logic [0:0][DB-1:0]     m_rd_data, m_wr_data;

    logic [NC-1:0]          b_rd_valid, b_rd_ready, b_wr_valid, b_wr_ready;
    logic [NC-1:0][AB-1:0]  b_rd_addr, b_wr_addr;
    logic [NC-1:0][DB-1:0]  b_rd_data, b_wr_data;
    logic [1:0]             b_m_rd_valid, b_m_rd_ready, b_m_wr_valid, b_m_wr_ready;
    logic [1:0][AB-1:0]     b_m_rd_addr, b_m_wr_addr;
    logic [1:0][DB-1:0]     b_m_rd_data, b_m_wr_data;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(1)) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rd_valid), .consumer_read_address(rd_addr),
        .consumer_read_ready(rd_ready), .consumer_read_data(rd_data),
        .consumer_write_valid(wr_valid), .consumer_write_address(wr_addr),
        .consumer_write_data(wr_data), .consumer_write_ready(wr_ready),
        .mem_read_valid(m_rd_valid), .mem_read_address(m_rd_addr),
        .mem_read_ready(m_rd_ready), .mem_read_data(m_rd_data),
        .mem_write_valid(m_wr_valid), .mem_write_address(m_wr_addr),
        .mem_write_data(m_wr_data), .mem_write_ready(m_wr_ready)
    );

    mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(2)) dut2 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(b_rd_valid), .consumer_read_address(b_rd_addr),
        .consumer_read_ready(b_rd_ready), .consumer_read_data(b_rd_data),
        .consumer_write_valid(b_wr_valid), .consumer_write_address(b_wr_addr),
        .consumer_write_data(b_wr_data), .consumer_write_ready(b_wr_ready),
        .mem_read_valid(b_m_rd_valid), .mem_read_address(b_m_rd_addr),
        .mem_read_ready(b_m_rd_ready), .mem_read_data(b_m_rd_data),
        .mem_write_valid(b_m_wr_valid), .mem_write_address(b_m_wr_addr),
        .mem_write_data(b_m_wr_data), .mem_write_ready(b_m_wr_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; rd_valid = '1; wr_valid = '1; m_rd_ready = 1'b1; m_wr_ready = 1'b1;
        tick(); tick();
        checks++; if (m_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_rd_valid got %b want 0", m_rd_valid); end
        checks++; if (m_rd_addr !== '0) begin errors++; $display("FAIL reset_mem_rd_addr got %h want 0", m_rd_addr); end
        checks++; if (rd_ready !== 4'b0) begin errors++; $display("FAIL reset_rd_ready got %b want 0", rd_ready); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        checks++; if (m_wr_valid !== 1'b0 || wr_ready !== 4'b0 || m_wr_data !== '0)
            begin errors++; $display("FAIL reset_write_outs got %b/%b/%h want 0", m_wr_valid, wr_ready, m_wr_data); end
        checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_rr_ptr got %0d want 0", dut.rr_ptr); end
        rd_valid = '0; wr_valid = '0; m_rd_ready = 1'b0; m_wr_ready = 1'b0; reset = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        rd_addr[2] = 8'h10; rd_valid[2] = 1'b1;
        tick();
        checks++; if (m_rd_valid !== 1'b1 || m_rd_addr[0] !== 8'h10)
            begin errors++; $display("FAIL single_grant got v=%b a=%h want v=1 a=10", m_rd_valid, m_rd_addr[0]); end
        tick(); tick();
        checks++; if (m_rd_valid !== 1'b1 || m_rd_addr[0] !== 8'h10 || rd_ready !== 4'b0)
            begin errors++; $display("FAIL single_hold got v=%b a=%h r=%b want 1/10/0", m_rd_valid, m_rd_addr[0], rd_ready); end
        tick();
        m_rd_ready = 1'b1; m_rd_data[0] = 8'hAB;
        tick();
        m_rd_ready = 1'b0; m_rd_data[0] = 8'h00;
        checks++; if (rd_ready !== 4'b0100 || rd_data[2] !== 8'hAB || m_rd_valid !== 1'b0)
            begin errors++; $display("FAIL single_done got r=%b d=%h v=%b want 0100/ab/0", rd_ready, rd_data[2], m_rd_valid); end
        checks++; if (dut.rr_ptr !== 2'd3) begin errors++; $display("FAIL single_rr_ptr got %0d want 3", dut.rr_ptr); end
        tick();
        checks++; if (rd_ready !== 4'b0100) begin errors++; $display("FAIL single_relay got %b want 0100", rd_ready); end
        rd_valid[2] = 1'b0;
        tick();
        checks++; if (rd_ready !== 4'b0 || dut.claimed !== 4'b0 || rd_data[2] !== 8'hAB)
            begin errors++; $display("FAIL single_release got r=%b c=%b d=%h want 0/0/ab", rd_ready, dut.claimed, rd_data[2]); end
    endtask

    task automatic test_contention();
        int n;
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < NC; i++) rd_addr[i] = 8'(8'h30 + i);
        rd_valid = '1;
        for (int k = 0; k < NC; k++) begin
            n = 0;
            do begin tick(); n++; end while (m_rd_valid !== 1'b1 && n < 10);
            checks++; if (m_rd_valid !== 1'b1) begin errors++; $display("FAIL contention_timeout k=%0d got %b want 1", k, m_rd_valid); end
            checks++; if (m_rd_addr[0] !== 8'(8'h30 + k)) begin errors++; $display("FAIL contention_order got %h want %h", m_rd_addr[0], 8'(8'h30 + k)); end
            checks++; if (dut.rr_ptr !== 2'((k + 1) % NC)) begin errors++; $display("FAIL contention_rr_ptr got %0d want %0d", dut.rr_ptr, (k + 1) % NC); end
            m_rd_ready = 1'b1; m_rd_data[0] = 8'(8'hC0 + k);
            tick();
            m_rd_ready = 1'b0;
            checks++; if (rd_ready !== 4'(1 << k) || rd_data[k] !== 8'(8'hC0 + k))
                begin errors++; $display("FAIL contention_done got r=%b d=%h want %b/%h", rd_ready, rd_data[k], 4'(1 << k), 8'(8'hC0 + k)); end
            rd_valid[k] = 1'b0;
            tick();
        end
    endtask

    task automatic test_read_write_same();
        rd_addr[0] = 8'h40; wr_addr[0] = 8'h44; wr_data[0] = 8'h99;
        rd_valid[0] = 1'b1; wr_valid[0] = 1'b1;
        tick();
        checks++; if (m_rd_valid !== 1'b1 || m_rd_addr[0] !== 8'h40 || m_wr_valid !== 1'b0)
            begin errors++; $display("FAIL rw_read_first got rv=%b a=%h wv=%b want 1/40/0", m_rd_valid, m_rd_addr[0], m_wr_valid); end
        m_rd_ready = 1'b1; m_rd_data[0] = 8'h5A;
        tick();
        m_rd_ready = 1'b0;
        checks++; if (rd_ready !== 4'b0001 || rd_data[0] !== 8'h5A)
            begin errors++; $display("FAIL rw_read_done got r=%b d=%h want 0001/5a", rd_ready, rd_data[0]); end
        rd_valid[0] = 1'b0;
        tick();
        checks++; if (rd_ready !== 4'b0 || m_wr_valid !== 1'b0)
            begin errors++; $display("FAIL rw_release got r=%b wv=%b want 0/0", rd_ready, m_wr_valid); end
        tick();
`ifdef MEM_ARB_WRITE_EN
        checks++; if (m_wr_valid !== 1'b1 || m_wr_addr[0] !== 8'h44 || m_wr_data[0] !== 8'h99)
            begin errors++; $display("FAIL rw_write_grant got v=%b a=%h d=%h want 1/44/99", m_wr_valid, m_wr_addr[0], m_wr_data[0]); end
        m_wr_ready = 1'b1;
        tick();
        m_wr_ready = 1'b0;
        checks++; if (wr_ready !== 4'b0001 || m_wr_valid !== 1'b0)
            begin errors++; $display("FAIL rw_write_done got r=%b v=%b want 0001/0", wr_ready, m_wr_valid); end
        wr_valid[0] = 1'b0;
        tick();
        checks++; if (wr_ready !== 4'b0) begin errors++; $display("FAIL rw_write_release got %b want 0", wr_ready); end
`else
        checks++; if (m_wr_valid !== 1'b0 || m_rd_valid !== 1'b0)
            begin errors++; $display("FAIL rw_write_ignored got wv=%b rv=%b want 0/0", m_wr_valid, m_rd_valid); end
        wr_valid[0] = 1'b0;
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        rd_addr[1] = 8'h77; rd_valid[1] = 1'b1;
        tick();
        checks++; if (m_rd_valid !== 1'b1) begin errors++; $display("FAIL midrst_grant got %b want 1", m_rd_valid); end
        reset = 1'b1; m_rd_ready = 1'b1; m_rd_data[0] = 8'hEE; rd_valid[1] = 1'b0;
        tick();
        checks++; if (m_rd_valid !== 1'b0 || m_rd_addr !== '0 || rd_ready !== 4'b0 || rd_data !== '0)
            begin errors++; $display("FAIL midrst_outputs got v=%b a=%h r=%b d=%h want all 0", m_rd_valid, m_rd_addr, rd_ready, rd_data); end
        checks++; if (dut.state[0] !== IDLE || dut.rr_ptr !== 2'd0 || dut.claimed !== 4'b0)
            begin errors++; $display("FAIL midrst_state got s=%0d p=%0d c=%b want 0/0/0", dut.state[0], dut.rr_ptr, dut.claimed); end
        reset = 1'b0; m_rd_ready = 1'b0;
        tick();
        checks++; if (rd_ready !== 4'b0 || m_rd_valid !== 1'b0)
            begin errors++; $display("FAIL midrst_after got r=%b v=%b want 0/0", rd_ready, m_rd_valid); end
    endtask

    task automatic test_two_channels();
`ifdef MEM_ARB_WRITE_EN
        b_wr_addr[1] = 8'h20; b_wr_data[1] = 8'h55; b_wr_addr[3] = 8'h21; b_wr_data[3] = 8'h66;
        b_wr_valid[1] = 1'b1; b_wr_valid[3] = 1'b1;
        tick();
        checks++; if (b_m_wr_valid !== 2'b11 || b_m_wr_addr[0] !== 8'h20 || b_m_wr_addr[1] !== 8'h21)
            begin errors++; $display("FAIL dual_grant got v=%b a0=%h a1=%h want 11/20/21", b_m_wr_valid, b_m_wr_addr[0], b_m_wr_addr[1]); end
        checks++; if (b_m_wr_data[0] !== 8'h55 || b_m_wr_data[1] !== 8'h66)
            begin errors++; $display("FAIL dual_data got %h/%h want 55/66", b_m_wr_data[0], b_m_wr_data[1]); end
`else
        b_rd_addr[1] = 8'h20; b_rd_addr[3] = 8'h21;
        b_rd_valid[1] = 1'b1; b_rd_valid[3] = 1'b1;
        tick();
        checks++; if (b_m_rd_valid !== 2'b11 || b_m_rd_addr[0] !== 8'h20 || b_m_rd_addr[1] !== 8'h21)
            begin errors++; $display("FAIL dual_grant got v=%b a0=%h a1=%h want 11/20/21", b_m_rd_valid, b_m_rd_addr[0], b_m_rd_addr[1]); end
`endif
        checks++; if (dut2.claimed !== 4'b1010 || dut2.rr_ptr !== 2'd0)
            begin errors++; $display("FAIL dual_claims got c=%b p=%0d want 1010/0", dut2.claimed, dut2.rr_ptr); end
`ifdef MEM_ARB_WRITE_EN
        b_m_wr_ready = 2'b11;
        tick();
        b_m_wr_ready = 2'b00;
        checks++; if (b_wr_ready !== 4'b1010) begin errors++; $display("FAIL dual_done got %b want 1010", b_wr_ready); end
        b_wr_valid = '0;
        tick();
        checks++; if (b_wr_ready !== 4'b0 || dut2.claimed !== 4'b0)
            begin errors++; $display("FAIL dual_release got r=%b c=%b want 0/0", b_wr_ready, dut2.claimed); end
`else
        b_m_rd_ready = 2'b11; b_m_rd_data[0] = 8'h11; b_m_rd_data[1] = 8'h22;
        tick();
        b_m_rd_ready = 2'b00;
        checks++; if (b_rd_ready !== 4'b1010 || b_rd_data[1] !== 8'h11 || b_rd_data[3] !== 8'h22)
            begin errors++; $display("FAIL dual_done got r=%b d1=%h d3=%h want 1010/11/22", b_rd_ready, b_rd_data[1], b_rd_data[3]); end
        b_rd_valid = '0;
        tick();
        checks++; if (b_rd_ready !== 4'b0 || dut2.claimed !== 4'b0)
            begin errors++; $display("FAIL dual_release got r=%b c=%b want 0/0", b_rd_ready, dut2.claimed); end
`endif
    endtask

`ifndef MEM_ARB_WRITE_EN
    task automatic test_write_disabled();
        wr_addr[2] = 8'h50; wr_data[2] = 8'h12; wr_valid[2] = 1'b1; m_wr_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (m_wr_valid !== 1'b0 || wr_ready !== 4'b0 || m_rd_valid !== 1'b0)
                begin errors++; $display("FAIL wr_disabled cycle %0d got wv=%b wr=%b rv=%b want 0/0/0", i, m_wr_valid, wr_ready, m_rd_valid); end
        end
        wr_valid = '0; m_wr_ready = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        rd_valid = '0; rd_addr = '0; wr_valid = '0; wr_addr = '0; wr_data = '0;
        m_rd_ready = '0; m_rd_data = '0; m_wr_ready = '0;
        b_rd_valid = '0; b_rd_addr = '0; b_wr_valid = '0; b_wr_addr = '0; b_wr_data = '0;
        b_m_rd_ready = '0; b_m_rd_data = '0; b_m_wr_ready = '0;
        test_reset();
        test_single_read();
        test_contention();
        test_read_write_same();
        test_reset_mid();
        test_two_channels();
`ifndef MEM_ARB_WRITE_EN
        test_write_disabled();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
